// File: rtl/rotl_pkg.sv
// Shared types and helpers for the left-rotate register with counted rotation.
package rotl_pkg;

    typedef enum logic {
        ROTL_IDLE = 1'b0,
        ROTL_ROT  = 1'b1
    } rotl_state_t;

    // Width of amt/rot_cnt: max(1, clog2(DW)).
    function automatic int rotl_cw(input int dw);
        int w;
        w = $clog2(dw);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rotl_pos_cnt.sv
// Modulo-DW position counter: counts single-bit left rotations since the last clear.
module rotl_pos_cnt
    import rotl_pkg::*;
#(
    parameter  int DW = 4,
    localparam int CW = rotl_cw(DW)
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] rot_cnt,
    output logic          aligned
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          aligned_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            // Explicit wrap keeps non-power-of-two DW correct.
            cnt_d = (cnt_q == CW'(DW - 1)) ? '0 : cnt_q + CW'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            cnt_q     <= '0;
            aligned_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            aligned_q <= (cnt_d == '0);
        end
    end

    assign rot_cnt = cnt_q;
    assign aligned = aligned_q;

endmodule

// File: rtl/left_rotate_reg_ctl.sv
// Left-rotate register with free-run rotate and counted-rotation start/busy/done command.
// Position tracking (rot_cnt/aligned) is compiled in only when ROTL_POS_TRACK_EN is defined.
module left_rotate_reg_ctl
    import rotl_pkg::*;
#(
    parameter  int DW = 4,
    localparam int CW = rotl_cw(DW)
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          load,
    input  logic          en,
    input  logic          start,
    input  logic [CW-1:0] amt,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] q,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] rot_cnt,
    output logic          aligned
);

    rotl_state_t   state_q;
    logic [DW-1:0] rot_q;
    logic [DW-1:0] rot_step;
    logic [CW-1:0] remaining_q;
    logic          busy_q;
    logic          done_q;

    assign rot_step = {rot_q[DW-2:0], rot_q[DW-1]};

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            rot_q       <= '0;
            state_q     <= ROTL_IDLE;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (load) begin
            // Load wins in either state; in ROT it aborts without a done pulse.
            rot_q   <= data;
            state_q <= ROTL_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ROTL_IDLE: begin
                    if (start) begin
                        if (amt == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= ROTL_ROT;
                            busy_q      <= 1'b1;
                            remaining_q <= amt;
                        end
                    end else if (en) begin
                        rot_q <= rot_step;
                    end
                end
                ROTL_ROT: begin
                    rot_q       <= rot_step;
                    remaining_q <= remaining_q - CW'(1);
                    if (remaining_q == CW'(1)) begin
                        state_q <= ROTL_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ROTL_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = rot_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef ROTL_POS_TRACK_EN
    logic step_en;

    // Mirrors exactly the edges on which rot_q takes rot_step; load clears via clr.
    assign step_en = (state_q == ROTL_ROT) || (!start && en);

    rotl_pos_cnt #(.DW(DW)) u_pos_cnt (
        .clk      (clk),
        .sync_rst (sync_rst),
        .clr      (load),
        .inc      (step_en),
        .rot_cnt  (rot_cnt),
        .aligned  (aligned)
    );
`else
    assign rot_cnt = '0;
    assign aligned = 1'b0;
`endif

endmodule
